sm_accumulator: RTL and testbench

//  Streaming reducer for 16-bit sign-magnitude operands (bit15 = sign, [14:0] = magnitude). Converts each

---
 rtl/sm_pkg.sv | 50 +++++
 rtl/sm2tc_conv.sv | 17 +
 rtl/sm_accumulator.sv | 113 +++++++++++
 tb/tb_sm_accumulator.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sm_pkg.sv
// Shared sign-magnitude helpers: format constants, accumulator FSM state type,
// and conversions between sign-magnitude and two's complement.
package sm_pkg;

    localparam int unsigned         SM_W        = 16;
    localparam logic [SM_W-2:0]     SM_MAX      = 15'h7FFF;
    localparam logic [SM_W-1:0]     SM_NEG_ZERO = 16'h8000;

    typedef enum logic {
        ACC,
        OUT
    } state_t;

    // Sign-magnitude to two's complement, sign-extended from bit width-1 upward.
    // Negative zero folds to zero. width must be in 1..64.
    function automatic logic [63:0] sm2tc(input logic [SM_W-1:0] sm, input int unsigned width);
        logic [63:0]        full;
        logic signed [63:0] t;
        if (!sm[SM_W-1] || sm == SM_NEG_ZERO) begin
            full = 64'(sm[SM_W-2:0]);
        end else begin
            full = -64'(sm[SM_W-2:0]);
        end
        t = full << (64 - width);
        t = t >>> (64 - width);
        return t;
    endfunction

    // Two's complement to sign-magnitude with symmetric saturation; returns {sat, sm}.
    // Zero is always emitted as +0.
    function automatic logic [SM_W:0] tc2sm_sat(input logic signed [63:0] tc);
        logic signed [63:0] lim;
        logic [SM_W-2:0]    mag;
        lim = 64'(SM_MAX);
        if (tc > lim) begin
            return {1'b1, 1'b0, SM_MAX};
        end else if (tc < -lim) begin
            return {1'b1, 1'b1, SM_MAX};
        end else if (tc == 64'sd0) begin
            return '0;
        end else if (tc < 64'sd0) begin
            mag = (SM_W-1)'(-tc);
            return {1'b0, 1'b1, mag};
        end else begin
            mag = (SM_W-1)'(tc);
            return {1'b0, 1'b0, mag};
        end
    endfunction

endpackage

// File: rtl/sm2tc_conv.sv
// Combinational operand converter: sign-magnitude in, ACC_W-bit two's complement out.
module sm2tc_conv
    import sm_pkg::*;
#(
    parameter int unsigned DATA_W = SM_W,
    parameter int unsigned ACC_W  = 24
) (
    input  logic [DATA_W-1:0] sm,
    output logic [ACC_W-1:0]  tc
);

    // Convert and sign-extend to accumulator width; -0 becomes 0.
    always_comb begin
        tc = ACC_W'(sm2tc(sm, ACC_W));
    end

endmodule

// File: rtl/sm_accumulator.sv
// Streaming sign-magnitude packet reducer: converts operands to two's complement,
// sums each last-terminated packet and returns a saturated sign-magnitude total.
// DATA_W is expected to equal SM_W; ACC_W must exceed DATA_W.
module sm_accumulator
    import sm_pkg::*;
#(
    parameter int unsigned DATA_W = SM_W,
    parameter int unsigned ACC_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_last,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_sat,
    output logic              out_ovf
);

    state_t           state, state_nx;
    logic [ACC_W-1:0] in_tc;
    logic [ACC_W-1:0] s1_op;
    logic             s1_valid;
    logic             s1_last;
    logic [ACC_W-1:0] acc;
    logic [ACC_W-1:0] sum;
    logic             ovf_flag;
    logic             add_ovf;
    logic [SM_W:0]    conv;
    logic             accept;

    sm2tc_conv #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
    ) u_conv (
        .sm (in_data),
        .tc (in_tc)
    );

    // Next state, input backpressure, adder, overflow detect and output conversion.
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        case (state)
            ACC: begin
                in_ready = rst_n & ~(s1_valid & s1_last);
                if (s1_valid && s1_last) begin
                    state_nx = OUT;
                end
            end
            OUT: begin
                if (out_valid && out_ready) begin
                    state_nx = ACC;
                end
            end
            default: state_nx = ACC;
        endcase
        accept  = in_valid & in_ready;
        sum     = acc + s1_op;
        add_ovf = (acc[ACC_W-1] == s1_op[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
        conv    = tc2sm_sat({{(64-ACC_W){sum[ACC_W-1]}}, sum});
    end

    // Stage-1 register for accepted operands.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_op    <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_op   <= in_tc;
                s1_last <= in_last;
            end
        end
    end

    // FSM state, accumulator, sticky overflow and held output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ACC;
            acc       <= '0;
            ovf_flag  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            out_ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            if (state == ACC && s1_valid) begin
                if (s1_last) begin
                    out_data  <= conv[SM_W-1:0];
                    out_sat   <= conv[SM_W];
                    out_ovf   <= ovf_flag | add_ovf;
                    out_valid <= 1'b1;
                    acc       <= '0;
                    ovf_flag  <= 1'b0;
                end else begin
                    acc      <= sum;
                    ovf_flag <= ovf_flag | add_ovf;
                end
            end
            if (state == OUT && out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sm_accumulator.sv
// Scoreboard bench for sm_accumulator: two instances (ACC_W=24 and ACC_W=17) share stimulus;
// an integer reference model predicts each packet result at acceptance of its last beat.
module tb_sm_accumulator;

    typedef struct {
        logic [15:0] data;
        logic        sat;
        logic        ovf;
    } res_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_data;
    logic        in_last;
    logic        out_ready;
    logic        in_ready,  out_valid,  out_sat,  out_ovf;
    logic [15:0] out_data;
    logic        in_ready17, out_valid17, out_sat17, out_ovf17;
    logic [15:0] out_data17;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   acc_cyc = 0;
    int   rdy_mode = 0;
    res_t q24[$];
    res_t q17[$];
    res_t got24, got17;
    logic [15:0] pkt[$];
    logic [15:0] stim[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sm_accumulator #(.DATA_W(16), .ACC_W(24)) u_dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_sat(out_sat), .out_ovf(out_ovf)
    );

    sm_accumulator #(.DATA_W(16), .ACC_W(17)) u_dut17 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready17),
        .in_data(in_data), .in_last(in_last), .out_valid(out_valid17), .out_ready(out_ready),
        .out_data(out_data17), .out_sat(out_sat17), .out_ovf(out_ovf17)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference: exact integer sum with explicit modular wrap; overflow whenever wrap alters the value.
    function automatic res_t model(input int width);
        res_t   r;
        longint modv, half, a, v, s, w;
        bit     ovf;
        modv = longint'(1) << width;
        half = modv >> 1;
        a = 0;
        ovf = 0;
        foreach (pkt[i]) begin
            v = longint'(pkt[i][14:0]);
            if (pkt[i][15]) v = -v;
            s = a + v;
            w = s;
            if (w >= half) w -= modv;
            else if (w < -half) w += modv;
            if (w != s) ovf = 1;
            a = w;
        end
        r.ovf = ovf;
        r.sat = 1'b0;
        if (a > 32767) begin
            r.data = 16'h7FFF; r.sat = 1'b1;
        end else if (a < -32767) begin
            r.data = 16'hFFFF; r.sat = 1'b1;
        end else if (a == 0) begin
            r.data = 16'h0000;
        end else if (a < 0) begin
            r.data = 16'h8000 | 16'(-a);
        end else begin
            r.data = 16'(a);
        end
        return r;
    endfunction

    task automatic drive_beat(input logic [15:0] d, input logic l, input int gap_max);
        bit ok;
        if (gap_max > 0) begin
            repeat ($urandom_range(0, gap_max)) begin
                in_valid = 1'b0;
                in_data  = 16'($urandom);
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        ok = 0;
        for (int t = 0; t < 300 && !ok; t++) begin
            @(negedge clk);
            if (in_ready) begin
                ok = 1;
                acc_cyc = cyc;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (!ok) begin
            chk("accept_timeout", 0, 1);
        end else begin
            pkt.push_back(d);
            if (l) begin
                q24.push_back(model(24));
                q17.push_back(model(17));
                pkt.delete();
            end
        end
    endtask

    task automatic send_stim(input int gap_max);
        for (int i = 0; i < stim.size(); i++) begin
            drive_beat(stim[i], (i == stim.size() - 1), gap_max);
        end
        stim.delete();
    endtask

    task automatic wait_drain();
        for (int t = 0; t < 400 && q24.size() != 0; t++) @(posedge clk);
        #1;
        if (q24.size() != 0) chk("drain_timeout", q24.size(), 0);
    endtask

    // Output ready generation: constant, random, or left to the running test.
    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (rdy_mode == 1) out_ready = 1'($urandom_range(0, 1));
            else if (rdy_mode == 0) out_ready = 1'b1;
        end
    end

    // Monitor: latency, hold stability, backpressure while busy, scoreboard compare.
    initial begin
        bit          hold_prev = 0;
        bit          prev_valid = 0;
        logic [17:0] hold_val = '0;
        res_t        e24, e17;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                hold_prev  = 0;
                prev_valid = 0;
            end else begin
                if (hold_prev) begin
                    chk("hold_valid", out_valid, 1);
                    chk("hold_vals", {out_ovf, out_sat, out_data}, hold_val);
                end
                if (out_valid && !prev_valid) chk("latency", cyc - acc_cyc, 2);
                if (out_valid) chk("busy_in_ready", in_ready, 0);
                if (out_valid && out_ready) begin
                    if (q24.size() == 0) begin
                        chk("unexpected_out", 1, 0);
                    end else begin
                        e24 = q24.pop_front();
                        e17 = q17.pop_front();
                        got24.data = out_data;   got24.sat = out_sat;   got24.ovf = out_ovf;
                        got17.data = out_data17; got17.sat = out_sat17; got17.ovf = out_ovf17;
                        chk("data24", out_data, e24.data);
                        chk("sat24",  out_sat,  e24.sat);
                        chk("ovf24",  out_ovf,  e24.ovf);
                        chk("valid17", out_valid17, 1);
                        chk("data17", out_data17, e17.data);
                        chk("sat17",  out_sat17,  e17.sat);
                        chk("ovf17",  out_ovf17,  e17.ovf);
                    end
                end
                hold_prev  = out_valid && !out_ready;
                hold_val   = {out_ovf, out_sat, out_data};
                prev_valid = out_valid;
            end
        end
    end

    initial begin
        bit seen;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        chk("rst_in_ready",  in_ready,  0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data",  out_data,  0);
        chk("rst_out_sat",   out_sat,   0);
        chk("rst_out_ovf",   out_ovf,   0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", in_ready, 1);
        @(posedge clk); #1;

        // 1) mixed signs
        stim = '{16'h0005, 16'h8003, 16'h0002};
        send_stim(0);
        wait_drain();
        chk("t1_data", got24.data, 16'h0004);
        chk("t1_sat",  got24.sat,  0);
        chk("t1_ovf",  got24.ovf,  0);

        // 2) negative zeros
        stim = '{16'h8000, 16'h8000};
        send_stim(0);
        wait_drain();
        chk("t2_data", got24.data, 16'h0000);
        chk("t2_sat",  got24.sat,  0);

        // 3) saturation both ways
        stim = '{16'h7FFF, 16'h0001};
        send_stim(0);
        wait_drain();
        chk("t3p_data", got24.data, 16'h7FFF);
        chk("t3p_sat",  got24.sat,  1);
        stim = '{16'hFFFF, 16'h8005};
        send_stim(0);
        wait_drain();
        chk("t3n_data", got24.data, 16'hFFFF);
        chk("t3n_sat",  got24.sat,  1);

        // 4) held output, then accept right after handshake
        rdy_mode  = 2;
        out_ready = 1'b0;
        drive_beat(16'h8007, 1'b1, 0);
        seen = 0;
        for (int t = 0; t < 10 && !seen; t++) begin
            @(negedge clk);
            seen = out_valid;
        end
        chk("t4_valid_seen", seen, 1);
        for (int t = 0; t < 10; t++) begin
            @(negedge clk);
            chk("t4_hold_ready", in_ready, 0);
            chk("t4_hold_data", out_data, 16'h8007);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        chk("t4_hs_ready", in_ready, 0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_next_ready", in_ready, 1);
        @(posedge clk); #1;
        rdy_mode = 0;
        wait_drain();
        chk("t4_data", got24.data, 16'h8007);
        stim = '{16'h0003};
        send_stim(0);
        stim = '{16'h8001};
        send_stim(0);
        wait_drain();
        chk("t4_b2b_data", got24.data, 16'h8001);

        // 5) wrap in the narrow accumulator, flag clears on next packet
        stim = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
        send_stim(0);
        wait_drain();
        chk("t5_ovf17",  got17.ovf,  1);
        chk("t5_data17", got17.data, 16'h8004);
        chk("t5_ovf24",  got24.ovf,  0);
        stim = '{16'h0001};
        send_stim(0);
        wait_drain();
        chk("t5_clr_ovf17", got17.ovf, 0);
        chk("t5_clr_data17", got17.data, 16'h0001);

        // 6) reset mid-packet discards partial sum
        drive_beat(16'h0010, 1'b0, 0);
        drive_beat(16'h0010, 1'b0, 0);
        rst_n = 1'b0;
        pkt.delete();
        @(posedge clk); #1;
        rst_n = 1'b1;
        stim = '{16'h0003};
        send_stim(0);
        wait_drain();
        chk("t6_data", got24.data, 16'h0003);

        // random packets, random valid gaps and ready stalls
        rdy_mode = 1;
        for (int p = 0; p < 30; p++) begin
            int n;
            n = $urandom_range(1, 6);
            for (int b = 0; b < n; b++) begin
                case ($urandom_range(0, 7))
                    0:       stim.push_back(16'h8000);
                    1:       stim.push_back(16'h7FFF);
                    2:       stim.push_back(16'hFFFF);
                    default: stim.push_back(16'($urandom));
                endcase
            end
            send_stim(3);
        end
        wait_drain();
        rdy_mode = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("final_queue_empty", q24.size(), 0);
        chk("final_idle_valid", out_valid, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
